// File: rtl/dmac_engine.sv
// DMAC copy engine: pops {src, dst, size} descriptors and copies words memory-to-memory, one read then one write each.
// Optional DMAC_ENGINE_XFER_CNT_EN adds a saturating 16-bit count of completed writes on xfer_cnt.
module dmac_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic              fifo_empty,
    input  logic              fifo_rd_ack,
    input  logic              fifo_rd_err,
    input  logic [ADDR_W-1:0] fifo_sourceaddr,
    input  logic [ADDR_W-1:0] fifo_desaddr,
    input  logic [ADDR_W-1:0] fifo_datasize,
    output logic              fifo_rd_en,
    output logic              m_req,
    input  logic              m_grant,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic              busy,
    output logic              desc_done,
`ifdef DMAC_ENGINE_XFER_CNT_EN
    output logic              op_done,
    output logic [15:0]       xfer_cnt
`else
    output logic              op_done
`endif
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] POP       = 3'd1;
    localparam logic [2:0] WAIT_DESC = 3'd2;
    localparam logic [2:0] REQ       = 3'd3;
    localparam logic [2:0] RD        = 3'd4;
    localparam logic [2:0] RD_WAIT   = 3'd5;
    localparam logic [2:0] WR        = 3'd6;
    localparam logic [2:0] NEXT      = 3'd7;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] remain;
    logic [DATA_W-1:0] data;
    logic              more;
    logic              wr_done;

    assign more    = op_start && !fifo_empty;
    assign wr_done = (state == WR) && m_grant;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (more) state_nxt = POP;
            POP:       state_nxt = WAIT_DESC;
            WAIT_DESC: begin
                if (fifo_rd_ack)
                    state_nxt = (fifo_datasize == '0) ? NEXT : REQ;
                else if (fifo_rd_err)
                    state_nxt = IDLE;
            end
            REQ:       if (m_grant) state_nxt = RD;
            RD:        if (m_grant) state_nxt = RD_WAIT;
            RD_WAIT:   state_nxt = WR;
            WR:        if (m_grant) state_nxt = (remain == ONE) ? NEXT : RD;
            NEXT:      state_nxt = more ? POP : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            src    <= '0;
            dst    <= '0;
            remain <= '0;
            data   <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT_DESC && fifo_rd_ack) begin
                src    <= fifo_sourceaddr;
                dst    <= fifo_desaddr;
                remain <= fifo_datasize;
            end
            if (state == RD_WAIT)
                data <= m_din;
            // Address increments wrap naturally at 2^ADDR_W.
            if (wr_done) begin
                src    <= src + ONE;
                dst    <= dst + ONE;
                remain <= remain - ONE;
            end
        end
    end

    // Outputs decode straight from state so an async reset clears them in the same cycle.
    assign fifo_rd_en = (state == POP);
    assign m_req      = (state == REQ) || (state == RD) || (state == RD_WAIT) || (state == WR);
    assign m_wr       = (state == WR);
    assign m_addr     = (state == RD) ? src : ((state == WR) ? dst : '0);
    assign m_dout     = data;
    assign busy       = (state != IDLE);
    assign desc_done  = (state == NEXT);
    assign op_done    = (state == NEXT) && !more;

`ifdef DMAC_ENGINE_XFER_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            xfer_cnt <= '0;
        else if (wr_done && xfer_cnt != 16'hFFFF)
            xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dmac_engine.sv
// Bench for dmac_engine: behavioural FIFO/memory/arbiter model, expected-write scoreboard, directed scenarios.
module tb_dmac_engine;
    logic        clk, reset, op_start, fifo_empty, fifo_rd_ack, fifo_rd_err;
    logic [7:0]  fifo_sourceaddr, fifo_desaddr, fifo_datasize;
    logic        fifo_rd_en, m_req, m_grant, m_wr, busy, desc_done, op_done;
    logic [7:0]  m_addr;
    logic [31:0] m_dout, m_din;
`ifdef DMAC_ENGINE_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    dmac_engine #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .fifo_empty(fifo_empty),
        .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
        .fifo_sourceaddr(fifo_sourceaddr), .fifo_desaddr(fifo_desaddr), .fifo_datasize(fifo_datasize),
        .fifo_rd_en(fifo_rd_en), .m_req(m_req), .m_grant(m_grant), .m_addr(m_addr), .m_wr(m_wr),
        .m_dout(m_dout), .m_din(m_din), .busy(busy), .desc_done(desc_done),
`ifdef DMAC_ENGINE_XFER_CNT_EN
        .op_done(op_done), .xfer_cnt(xfer_cnt)
`else
        .op_done(op_done)
`endif
    );

    typedef struct packed { logic [7:0] s; logic [7:0] d; logic [7:0] n; } desc_t;
    typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;

    logic [31:0] mem [256];
    desc_t       fq[$];
    wr_t         exp_wr[$];
    int          pop_cyc[$], done_cyc[$], opd_cyc[$];
    int          cyc = 0, n_req = 0, held = 0, n_cmp = 0, n_bad = 0;
    logic        lie_empty = 0, drop_arm = 0;
    int          drop_left = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO, memory and arbiter responder; grant changes first so bus actions use the grant the DUT will see.
    initial begin
        desc_t hold;
        logic pend, pend_err;
        logic [31:0] rd_pipe;
        pend = 0; pend_err = 0; rd_pipe = 0; hold = '0;
        fifo_empty = 1; fifo_rd_ack = 0; fifo_rd_err = 0; m_din = 0;
        fifo_sourceaddr = 0; fifo_desaddr = 0; fifo_datasize = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 0; fifo_rd_ack = 0; fifo_rd_err = 0; rd_pipe = 0; m_din = 0;
            end else begin
                if (drop_left > 0) begin
                    drop_left--;
                    if (drop_left == 0) m_grant = 1;
                end else if (drop_arm && m_req && !m_wr && m_addr == 8'h20) begin
                    m_grant = 0; drop_left = 4; drop_arm = 0;
                end
                m_din = rd_pipe;
                rd_pipe = 0;
                if (m_req && m_grant) begin
                    if (m_wr) mem[m_addr] = m_dout;
                    else rd_pipe = mem[m_addr];
                end
                fifo_rd_ack = pend && !pend_err;
                fifo_rd_err = pend && pend_err;
                {fifo_sourceaddr, fifo_desaddr, fifo_datasize} = hold;
                pend = 0;
                if (fifo_rd_en) begin
                    pend = 1;
                    pend_err = (fq.size() == 0);
                    if (fq.size() > 0) hold = fq.pop_front();
                    else lie_empty = 0;
                end
            end
            fifo_empty = (fq.size() == 0) && !lie_empty;
        end
    end

    // Single compare process: every cycle, away from the active edge.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (fifo_rd_en) begin
                    pop_cyc.push_back(cyc);
                    chk("pop_busy", busy, 1);
                end
                if (m_req) n_req++;
                if (m_req && !m_grant) begin
                    held++;
                    chk("hold_addr", m_addr, 8'h20);
                    chk("hold_wr", m_wr, 0);
                end
                if (m_req && m_grant && m_wr) begin
                    if (exp_wr.size() == 0) chk("unexpected_wr", m_addr, 64'hFFFF);
                    else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", m_addr, e.a);
                        chk("wr_data", m_dout, e.d);
                    end
                end
                if (desc_done) begin
                    done_cyc.push_back(cyc);
                    chk("done_noreq", m_req, 0);
                end
                if (op_done) begin
                    opd_cyc.push_back(cyc);
                    chk("opdone_with_done", desc_done, 1);
                end
            end
        end
    end

    task automatic push_desc(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        wr_t w;
        logic [7:0] sa, da;
        fq.push_back({s, d, n});
        for (int i = 0; i < int'(n); i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            w.a = da;
            w.d = mem[sa];
            exp_wr.push_back(w);
        end
    endtask

    task automatic clr();
        pop_cyc.delete(); done_cyc.delete(); opd_cyc.delete();
        n_req = 0; held = 0;
    endtask

    task automatic run_until_opdone(input string nm, input int n);
        int k;
        k = 0;
        @(posedge clk); #2;
        op_start = 1;
        while (opd_cyc.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (opd_cyc.size() < n) chk({nm, "_timeout"}, opd_cyc.size(), n);
        #2;
        op_start = 0;
        repeat (2) @(posedge clk);
        #2;
        chk({nm, "_wr_drained"}, exp_wr.size(), 0);
    endtask

    task automatic chk_latency(input string nm, input int exp_lat);
        chk({nm, "_npop"}, pop_cyc.size(), 1);
        chk({nm, "_ndone"}, done_cyc.size(), 1);
        if (pop_cyc.size() > 0 && done_cyc.size() > 0)
            chk({nm, "_latency"}, done_cyc[0] - pop_cyc[0], exp_lat);
        if (opd_cyc.size() > 0 && done_cyc.size() > 0)
            chk({nm, "_opdone_cycle"}, opd_cyc[0], done_cyc[0]);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1; op_start = 0; m_grant = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", m_req, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_done", {desc_done, op_done}, 0);
        chk("rst_bus", {m_addr, m_wr, m_dout}, 0);
        @(negedge clk); reset = 0;

        // Grant withheld for 4 cycles during the first read of a 2-word copy.
        mem[8'h20] = 32'h1111_1111; mem[8'h21] = 32'h2222_2222;
        clr(); drop_arm = 1;
        push_desc(8'h20, 8'h60, 8'd2);
        run_until_opdone("drop", 1);
        chk_latency("drop", 13);
        chk("drop_held", held, 4);
        chk("drop_mem0", mem[8'h60], 32'h1111_1111);
        chk("drop_mem1", mem[8'h61], 32'h2222_2222);
`ifdef DMAC_ENGINE_XFER_CNT_EN
        chk("xfer_cnt_drop", xfer_cnt, 2);
`endif

        // Reset pulse in the middle of a write cycle.
        clr();
        mem[8'h30] = 32'h3333_0000;
        push_desc(8'h30, 8'h70, 8'd3);
        @(posedge clk); #2;
        op_start = 1;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #2;
            if (m_wr && m_req) found = 1;
        end
        chk("rstwr_found", found, 1);
        reset = 1;
        #1;
        chk("rstwr_req", m_req, 0);
        chk("rstwr_busy", busy, 0);
        chk("rstwr_rd_en", fifo_rd_en, 0);
        op_start = 0;
        @(posedge clk); #2;
        reset = 0;
        exp_wr.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("rstwr_idle", busy, 0);
        chk("rstwr_mem", mem[8'h70], 32'h0);

        // Plain 3-word copy, grant tied high.
        clr();
        mem[8'h10] = 32'hA0A0_0001; mem[8'h11] = 32'hB0B0_0002; mem[8'h12] = 32'hC0C0_0003;
        push_desc(8'h10, 8'h40, 8'd3);
        run_until_opdone("copy3", 1);
        chk_latency("copy3", 12);
        chk("copy3_memA", mem[8'h40], 32'hA0A0_0001);
        chk("copy3_memB", mem[8'h41], 32'hB0B0_0002);
        chk("copy3_memC", mem[8'h42], 32'hC0C0_0003);

        // Source address wraps from 0xFF to 0x00.
        clr();
        mem[8'hFE] = 32'hDEAD_00FE; mem[8'hFF] = 32'hDEAD_00FF; mem[8'h00] = 32'hDEAD_0000;
        push_desc(8'hFE, 8'h01, 8'd3);
        run_until_opdone("wrap", 1);
        chk("wrap_mem1", mem[8'h01], 32'hDEAD_00FE);
        chk("wrap_mem2", mem[8'h02], 32'hDEAD_00FF);
        chk("wrap_mem3", mem[8'h03], 32'hDEAD_0000);

        // Zero-length descriptor: no bus access at all.
        clr();
        push_desc(8'h50, 8'h90, 8'd0);
        run_until_opdone("size0", 1);
        chk_latency("size0", 2);
        chk("size0_noreq", n_req, 0);

        // Two queued descriptors back to back.
        clr();
        mem[8'h80] = 32'hF000_0080; mem[8'h81] = 32'hF000_0081; mem[8'h82] = 32'hF000_0082;
        push_desc(8'h80, 8'hA0, 8'd1);
        push_desc(8'h81, 8'hB0, 8'd2);
        run_until_opdone("two", 1);
        chk("two_npop", pop_cyc.size(), 2);
        chk("two_ndone", done_cyc.size(), 2);
        chk("two_nopd", opd_cyc.size(), 1);
        if (opd_cyc.size() > 0 && done_cyc.size() > 1)
            chk("two_opd_after_second", opd_cyc[0], done_cyc[1]);
        chk("two_memA0", mem[8'hA0], 32'hF000_0080);
        chk("two_memB0", mem[8'hB0], 32'hF000_0081);
        chk("two_memB1", mem[8'hB1], 32'hF000_0082);
`ifdef DMAC_ENGINE_XFER_CNT_EN
        chk("xfer_cnt_total", xfer_cnt, 9);
`endif

        // Pop against a FIFO that claims data but is empty: read error, straight back to IDLE.
        clr();
        @(posedge clk); #2;
        lie_empty = 1;
        op_start = 1;
        repeat (10) @(posedge clk);
        #2;
        op_start = 0;
        chk("err_npop", pop_cyc.size(), 1);
        chk("err_ndone", done_cyc.size(), 0);
        chk("err_nopd", opd_cyc.size(), 0);
        chk("err_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/dmac_engine.md
Name: dmac_engine

Overview:
Consumer end of the DMAC descriptor FIFO. Pops {source address, destination address, data size} descriptors while enabled. Executes each descriptor as word-by-word memory-to-memory copies over a single-master bus: one read, then one write per word. Sits between the descriptor FIFO and the bus arbiter, and reports per-descriptor and per-operation completion to the DMAC slave/interrupt logic.

Parameters:
DATA_W, 32, bus data width in bits
ADDR_W, 8, address width; must match the FIFO descriptor field width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op_start  input  1  level enable from DMAC control register; engine pops descriptors only while high
fifo_empty  input  1  descriptor FIFO empty flag
fifo_rd_ack  input  1  FIFO read acknowledge; descriptor fields valid in this cycle
fifo_rd_err  input  1  FIFO read error (pop while empty)
fifo_sourceaddr  input  ADDR_W  descriptor source address
fifo_desaddr  input  ADDR_W  descriptor destination address
fifo_datasize  input  ADDR_W  descriptor word count
fifo_rd_en  output  1  single-cycle pop request to FIFO
m_req  output  1  bus request to arbiter
m_grant  input  1  bus grant
m_addr  output  ADDR_W  bus address
m_wr  output  1  1 = write, 0 = read (valid when m_req and m_grant are both high)
m_dout  output  DATA_W  write data
m_din  input  DATA_W  read data, valid one cycle after the read address cycle
busy  output  1  high whenever state is not IDLE
desc_done  output  1  one-cycle pulse per completed descriptor
op_done  output  1  one-cycle pulse when the engine returns to IDLE after finishing descriptors

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Internal src/dst/remain/data registers 0.
- States: IDLE, POP, WAIT_DESC, REQ, RD, RD_WAIT, WR, NEXT.
- IDLE: if op_start=1 and fifo_empty=0, go to POP. Otherwise stay.
- POP: fifo_rd_en=1 for exactly this cycle. Go to WAIT_DESC.
- WAIT_DESC:
  - fifo_rd_ack=1: latch src, dst, remain. If remain==0, go to NEXT with no bus access. Otherwise go to REQ.
  - fifo_rd_err=1: go to IDLE without desc_done or op_done.
  - Neither: wait; there is no timeout.
- REQ: m_req=1. Go to RD on the first cycle m_grant=1.
- m_req stays high continuously from REQ through the final WR of a descriptor. It deasserts in NEXT.
- RD: m_addr=src, m_wr=0. Advance to RD_WAIT only in a cycle with m_grant=1; otherwise hold state and outputs.
- RD_WAIT: capture m_din into the data register. Go to WR.
- WR: m_addr=dst, m_wr=1, m_dout=data register. The action completes only in a cycle with m_grant=1; otherwise hold.
- On a completed WR:
  - src+=1 and dst+=1, modulo 2^ADDR_W (0xFF wraps to 0x00).
  - remain-=1.
  - If the new remain==0, go to NEXT. Otherwise go to RD.
- Throughput: 3 cycles per word with continuous grant.
- NEXT: desc_done=1, m_req=0.
  - op_start=1 and fifo_empty=0: go to POP (back-to-back descriptors).
  - Otherwise: go to IDLE and pulse op_done in the same NEXT cycle.
- op_start falling mid-descriptor: the current descriptor always completes; no further pops.
- fifo_rd_en never asserts outside POP. This guarantees at most one outstanding pop.

Optional Feature:
DMAC_ENGINE_XFER_CNT_EN:
- Defined: adds output xfer_cnt [15:0].
  - Cleared by reset.
  - Increments by 1 on every completed WR.
  - Saturates at 0xFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-WR (reset pulse during a WR cycle) -> same cycle: m_req=0, busy=0, fifo_rd_en=0; state IDLE after release.
- One descriptor {src=0x10, dst=0x40, size=3}, memory[0x10..0x12]=A,B,C, grant tied high -> mem[0x40..0x42]=A,B,C; desc_done and op_done pulse in the same cycle; 9 bus cycles between REQ exit and NEXT.
- Descriptor {src=0xFE, dst=0x01, size=3} -> reads 0xFE,0xFF,0x00; writes 0x01,0x02,0x03.
- Descriptor size=0 -> no m_req assertion; desc_done pulses 2 cycles after POP.
- Two queued descriptors, op_start high -> fifo_rd_en pulses twice; desc_done twice; op_done once, after the second.
- Grant dropped 4 cycles during a RD of a size=2 transfer -> m_addr and m_wr hold steady; copy correct; total latency +4 cycles. With macro defined, xfer_cnt=2.
